pacman_map_ram: RTL and testbench

- True dual-port synchronous RAM holding the Pac-Man maze map: 32 rows × 160 bits, one bit per tile column.
- Port A serves the game/render logic and port B serves the pellet/update logic. Both ports can read and write.
- After reset, the array is reloaded from a constant initial maze, so every game restart begins from a clean map.

---
 rtl/pacman_map_pkg.sv | 52 +++++
 rtl/map_ram_core.sv | 45 ++++
 rtl/pacman_map_ram.sv | 86 ++++++++
 tb/tb_pacman_map_ram.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pacman_map_pkg.sv
// Shared types and constants for the Pac-Man maze map RAM.
// MAP_INIT is the pristine maze (wall=1, path=0) restored on every reset.
package pacman_map_pkg;

  localparam int MAP_ROWS   = 32;
  localparam int MAP_COLS   = 160;
  localparam int MAP_ADDR_W = 5;

  typedef logic [MAP_COLS-1:0] map_row_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } init_state_t;

  // Rows 0 and 31 form the solid border; bit 159 and bit 0 are the side walls.
  localparam map_row_t MAP_INIT [0:MAP_ROWS-1] = '{
    160'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hBF7FEFFD_FFBF7FF9_9FFEFDFF_BFF7FEFD_FFBFEFFD,
    160'hA0400801_00204009_90020100_20040801_00204005,
    160'hAF7DEF7D_F7BEF7B9_9DEF7BEF_7DEF7DF7_BEF7BDF5,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hBFFC3FFC_3FFC3FF9_9FFC3FFC_3FFC3FFC_3FFC3FFD,
    160'h80040020_01000801_80100080_04002001_00080041,
    160'hFE07F03F_81FC0FE1_87F03F81_FC0FE07F_03F81FC1,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hBDEF7BDE_F7BDEF79_9EF7BDEF_7BDEF7BD_EF7BDEF5,
    160'h84210842_10842109_90842108_42108421_08421085,
    160'hF7FFDFFF_7FFDFFF9_9FFF7FFD_FFF7FFDF_FF7FFDFF,
    160'h81FF81FF_81FF8101_80FF81FF_81FF81FF_81FF81F1,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hFFE00FFE_00FFE001_800FFE00_FFE00FFE_00FFE001,
    160'h80000000_00000000_00000000_00000000_00000001,
    160'hFFE00FFE_00FFE001_800FFE00_FFE00FFE_00FFE001,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hBF7FEFFD_FFBF7FF9_9FFEFDFF_BFF7FEFD_FFBFEFFD,
    160'hC3C3C3C3_C3C3C3C1_83C3C3C3_C3C3C3C3_C3C3C3C3,
    160'h80181818_18181801_80181818_18181818_18181801,
    160'hBF7FEFFD_FFBF7FF9_9FFEFDFF_BFF7FEFD_FFBFEFFD,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'h9FFFE7FF_F9FFFE79_9E7FFF9F_FFE7FFF9_FFFE7FF9,
    160'h90000400_00100001_80002000_00800002_00000801,
    160'h97FFF5FF_FD7FFF59_9AFFFEBF_FFAFFFEB_FFFAFFF9,
    160'h80000000_00000001_80000000_00000000_00000001,
    160'hBFFFFFFD_FFFFFFF9_9FFFFFFF_BFFFFFFF_FFFFFFFD,
    160'h80000000_00000000_00000000_00000000_00000001,
    160'hAAAAAAAA_AAAAAAAB_D5555555_55555555_55555555,
    160'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
  };

endpackage

// File: rtl/map_ram_core.sv
// True dual-port RAM: write-through on the writing port, old data on the other
// port, port B wins a same-address double write.
module map_ram_core #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 160,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // NOTE: the array has no reset so it stays a plain RAM; its contents are
  // restored by the init sweep in the parent, not by reset_n.
  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;  // later assignment gives port B priority
  end

  // Reads sample mem before this edge's writes land, which yields old data
  // for the opposite port; the own port forwards its write data instead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_a <= '0;
      q_b <= '0;
    end else if (!rd_en) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= wren_a ? data_a : mem[address_a];
      q_b <= wren_b ? data_b : mem[address_b];
    end
  end

endmodule

// File: rtl/pacman_map_ram.sv
// Maze map RAM top: reloads MAP_INIT into every row after reset, then hands
// both ports to the game and pellet logic.
module pacman_map_ram
  import pacman_map_pkg::*;
#(
  parameter int ADDR_W = MAP_ADDR_W,
  parameter int DATA_W = MAP_COLS,
  parameter int DEPTH  = MAP_ROWS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_b,
  output logic              init_done
);

  init_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              mem_wren_a, mem_wren_b, rd_en;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_data_a;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= (state_q == ST_RUN);
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_wren_a = wren_a;
    mem_addr_a = address_a;
    mem_data_a = data_a;
    mem_wren_b = wren_b;
    rd_en      = 1'b1;
    case (state_q)
      ST_INIT: begin
        // The sweep owns port A; user writes are dropped and reads return 0.
        mem_wren_a = 1'b1;
        mem_addr_a = cnt_q;
        mem_data_a = MAP_INIT[cnt_q];
        mem_wren_b = 1'b0;
        rd_en      = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  map_ram_core #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_en    (rd_en),
    .address_a(mem_addr_a),
    .data_a   (mem_data_a),
    .wren_a   (mem_wren_a),
    .q_a      (q_a),
    .address_b(address_b),
    .data_b   (data_b),
    .wren_b   (wren_b & mem_wren_b),
    .q_b      (q_b)
  );

endmodule

// File: tb/tb_pacman_map_ram.sv
// Scoreboard bench for pacman_map_ram: a row-array reference model predicts
// each port's read data; a monitor compares once init_done is high.
module tb_pacman_map_ram;
  import pacman_map_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [MAP_ADDR_W-1:0] address_a, address_b;
  map_row_t              data_a, data_b, q_a, q_b;
  logic                  wren_a, wren_b, init_done;

  always #5 clock = ~clock;

  pacman_map_ram dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .address_a(address_a),
    .data_a   (data_a),
    .wren_a   (wren_a),
    .q_a      (q_a),
    .address_b(address_b),
    .data_b   (data_b),
    .wren_b   (wren_b),
    .q_b      (q_b),
    .init_done(init_done)
  );

  typedef struct {
    int       idx;
    bit       chk_a;
    map_row_t exp_a;
    map_row_t exp_b;
  } exp_t;

  exp_t     sb[$];
  exp_t     mon_e;
  map_row_t model [0:MAP_ROWS-1];
  int       n_checks = 0;
  int       n_pass   = 0;
  int       n_issued = 0;

  task automatic check(string name, map_row_t act, map_row_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_model();
    for (int i = 0; i < MAP_ROWS; i++) model[i] = MAP_INIT[i];
  endtask

  function automatic map_row_t rand_row();
    map_row_t r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One RUN-mode cycle: apply inputs, predict both read results, update model.
  task automatic drive(input bit wa, input logic [MAP_ADDR_W-1:0] aa, input map_row_t da,
                       input bit wb, input logic [MAP_ADDR_W-1:0] ab, input map_row_t db);
    exp_t e;
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    @(posedge clock);
    e.idx   = n_issued++;
    // A same-row double write leaves port A's own read-back undefined.
    e.chk_a = !(wa && wb && aa == ab);
    e.exp_a = wa ? da : model[aa];
    e.exp_b = wb ? db : model[ab];
    if (wa) model[aa] = da;
    if (wb) model[ab] = db;
    sb.push_back(e);
    @(negedge clock);
  endtask

  // Counts rising edges from reset release to init_done, pushing ignored
  // writes into row 3 and probing the forced-zero outputs along the way.
  task automatic wait_init(string name);
    int n = 0;
    wren_a = 1'b1; address_a = 5'd3; data_a = '0;
    wren_b = 1'b1; address_b = 5'd20; data_b = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (i == 10) check({name, "_q_b_zero"}, q_b, '0);
      if (i == 20) begin
        wren_a = 1'b0;
        wren_b = 1'b0;
      end
      if (init_done) begin
        n = i;
        break;
      end
    end
    check(name, map_row_t'(n), map_row_t'(33));
    @(negedge clock);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (init_done && sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.chk_a) check($sformatf("q_a#%0d", mon_e.idx), q_a, mon_e.exp_a);
        check($sformatf("q_b#%0d", mon_e.idx), q_b, mon_e.exp_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit                    wa, wb;
    logic [MAP_ADDR_W-1:0] aa, ab;

    reset_n = 1'b0;
    wren_a = 1'b0; wren_b = 1'b0;
    address_a = '0; address_b = '0;
    data_a = '0; data_b = '0;
    #1;
    check("rst_q_a", q_a, '0);
    check("rst_q_b", q_b, '0);
    check("rst_init_done", map_row_t'(init_done), '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_latency");
    load_model();

    drive(0, 5'd0, 'x, 0, 5'd20, 'x);
    drive(0, 5'd0, 'x, 0, 5'd13, 'x);
    drive(0, 5'd0, 'x, 0, 5'd13, 'x);
    drive(0, 5'd0, 'x, 1, 5'd13, 160'h1);
    drive(0, 5'd13, 'x, 0, 5'd20, 'x);
    drive(1, 5'd5, {160{1'b1}}, 0, 5'd20, 'x);
    drive(1, 5'd7, 160'hA5, 0, 5'd7, 'x);
    drive(0, 5'd7, 'x, 0, 5'd7, 'x);
    drive(1, 5'd9, 160'h1, 1, 5'd9, 160'h2);
    drive(0, 5'd9, 'x, 0, 5'd3, 'x);

    for (int i = 0; i < 400; i++) begin
      wa = ($urandom_range(0, 3) == 0);
      wb = ($urandom_range(0, 3) == 0);
      aa = MAP_ADDR_W'($urandom_range(0, MAP_ROWS - 1));
      ab = (i % 16 == 0) ? aa : MAP_ADDR_W'($urandom_range(0, MAP_ROWS - 1));
      drive(wa, aa, wa ? rand_row() : 'x, wb, ab, wb ? rand_row() : 'x);
    end
    check("scoreboard_empty_run", map_row_t'(sb.size()), '0);

    drive(0, 5'd0, 'x, 0, 5'd31, 'x);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_q_a", q_a, '0);
    check("async_rst_q_b", q_b, '0);
    check("async_rst_init_done", map_row_t'(init_done), '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_q_a", q_a, '0);
    check("abort_q_b", q_b, '0);
    check("abort_init_done", map_row_t'(init_done), '0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("reinit_latency");
    load_model();

    drive(0, 5'd0, 'x, 0, 5'd13, 'x);
    drive(0, 5'd5, 'x, 0, 5'd9, 'x);
    drive(0, 5'd7, 'x, 0, 5'd3, 'x);
    drive(0, 5'd31, 'x, 0, 5'd20, 'x);
    check("scoreboard_empty_end", map_row_t'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
